// File: rtl/mmc1_serial_writer.sv
// Programs an MMC1 mapper over its 5-bit serial port, LSB first, with idle gap cycles between writes.
// Optional MMC1_RESET_PREFIX_EN adds a shift-register reset write (8'h80) ahead of each transaction.
module mmc1_serial_writer #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter logic [12:0] ADDR_LOW   = 13'h0000
) (
  input  logic        clk_cpu,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_sel,
  input  logic [4:0]  req_val,
  input  logic        bus_gnt,
  output logic [14:0] cpu_addr,
  output logic [7:0]  cpu_data_o,
  output logic        cpu_rw,
  output logic        romsel,
  output logic        done,
  output logic [4:0]  shadow_ctrl,
  output logic [4:0]  shadow_chr0,
  output logic [4:0]  shadow_chr1,
  output logic [4:0]  shadow_prg
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef MMC1_RESET_PREFIX_EN
    S_RSTW  = 3'd1,
`endif
    S_WRITE = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state, next_state;
  logic [1:0]  sel_q;
  logic [4:0]  val_q;
  logic [2:0]  bit_cnt;
  logic [3:0]  gap_cnt;
  logic        accept;
  logic        gap_last;
`ifdef MMC1_RESET_PREFIX_EN
  logic        prefix_q;
`endif

  assign accept   = (state == S_IDLE) && req_valid;
  assign gap_last = (gap_cnt == GAP_LAST);

  always_ff @(posedge clk_cpu) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
`ifdef MMC1_RESET_PREFIX_EN
          next_state = S_RSTW;
`else
          next_state = S_WRITE;
`endif
        end
      end
`ifdef MMC1_RESET_PREFIX_EN
      S_RSTW:  if (bus_gnt) next_state = S_GAP;
`endif
      S_WRITE: if (bus_gnt) next_state = S_GAP;
      S_GAP: begin
        if (gap_last) begin
`ifdef MMC1_RESET_PREFIX_EN
          if (prefix_q)              next_state = S_WRITE;
          else if (bit_cnt == 3'd4)  next_state = S_DONE;
          else                       next_state = S_WRITE;
`else
          if (bit_cnt == 3'd4) next_state = S_DONE;
          else                 next_state = S_WRITE;
`endif
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Bus strobes decode the state register directly so a stalled grant never consumes a bit.
  always_comb begin
    req_ready  = 1'b0;
    done       = 1'b0;
    cpu_rw     = 1'b1;
    romsel     = 1'b0;
    cpu_addr   = '0;
    cpu_data_o = '0;
    unique case (state)
      S_IDLE: req_ready = 1'b1;
`ifdef MMC1_RESET_PREFIX_EN
      S_RSTW: begin
        if (bus_gnt) begin
          cpu_rw     = 1'b0;
          romsel     = 1'b1;
          cpu_addr   = {sel_q, ADDR_LOW};
          cpu_data_o = 8'h80;
        end
      end
`endif
      S_WRITE: begin
        if (bus_gnt) begin
          cpu_rw     = 1'b0;
          romsel     = 1'b1;
          cpu_addr   = {sel_q, ADDR_LOW};
          cpu_data_o = {7'b0, val_q[bit_cnt]};
        end
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      sel_q       <= '0;
      val_q       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      shadow_ctrl <= 5'h0C;
      shadow_chr0 <= '0;
      shadow_chr1 <= '0;
      shadow_prg  <= '0;
`ifdef MMC1_RESET_PREFIX_EN
      prefix_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        sel_q    <= req_sel;
        val_q    <= req_val;
        bit_cnt  <= '0;
`ifdef MMC1_RESET_PREFIX_EN
        prefix_q <= 1'b1;
`endif
      end

      if (state == S_GAP && !gap_last) gap_cnt <= gap_cnt + 4'd1;
      else                             gap_cnt <= '0;

      if (state == S_GAP && gap_last) begin
`ifdef MMC1_RESET_PREFIX_EN
        if (prefix_q)             prefix_q <= 1'b0;
        else if (bit_cnt != 3'd4) bit_cnt  <= bit_cnt + 3'd1;
`else
        if (bit_cnt != 3'd4) bit_cnt <= bit_cnt + 3'd1;
`endif
      end

`ifdef MMC1_RESET_PREFIX_EN
      if (state == S_RSTW && bus_gnt) shadow_ctrl <= shadow_ctrl | 5'h0C;
`endif

      if (state == S_DONE) begin
        unique case (sel_q)
          2'd0: shadow_ctrl <= val_q;
          2'd1: shadow_chr0 <= val_q;
          2'd2: shadow_chr1 <= val_q;
          2'd3: shadow_prg  <= val_q;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmc1_serial_writer.sv
// Scoreboard bench for mmc1_serial_writer: stimulus queues expected writes/done, a negedge monitor checks them.
module tb_mmc1_serial_writer;

  localparam int unsigned GAP = 1;
  localparam logic [12:0] ALOW = 13'h1A5A;
`ifdef MMC1_RESET_PREFIX_EN
  localparam int P = 1 + GAP;
`else
  localparam int P = 0;
`endif

  logic        clk_cpu = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_sel = '0;
  logic [4:0]  req_val = '0;
  logic        bus_gnt = 1'b1;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_o;
  logic        cpu_rw, romsel, done;
  logic [4:0]  shadow_ctrl, shadow_chr0, shadow_chr1, shadow_prg;

  mmc1_serial_writer #(.GAP_CYCLES(GAP), .ADDR_LOW(ALOW)) dut (
    .clk_cpu(clk_cpu), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_val(req_val), .bus_gnt(bus_gnt), .cpu_addr(cpu_addr),
    .cpu_data_o(cpu_data_o), .cpu_rw(cpu_rw), .romsel(romsel), .done(done),
    .shadow_ctrl(shadow_ctrl), .shadow_chr0(shadow_chr0), .shadow_chr1(shadow_chr1),
    .shadow_prg(shadow_prg)
  );

  always #5 clk_cpu = ~clk_cpu;

  typedef struct { int cyc; logic [14:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int cyc; logic [19:0] sh; } dn_t;

  wr_t wq[$];
  dn_t dq[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int lo_from = 0, lo_to = 0;
  logic [4:0] m_sh[4];
  logic        sh_pending = 1'b0;
  logic [19:0] exp_sh;
  logic        prev_wr = 1'b0;

  always @(posedge clk_cpu) cyc <= cyc + 1;

  always @(posedge clk_cpu) begin
    #1 bus_gnt = !(cyc >= lo_from && cyc < lo_to);
  end

  // Monitor: compares every bus write and every done pulse against the queued expectations.
  always @(negedge clk_cpu) begin
    wr_t w;
    dn_t d;
    if (sh_pending) begin
      sh_pending = 1'b0;
      checks++;
      if ({shadow_prg, shadow_chr1, shadow_chr0, shadow_ctrl} !== exp_sh) begin
        errors++;
        $display("FAIL shadows cyc=%0d got=%h want=%h", cyc,
                 {shadow_prg, shadow_chr1, shadow_chr0, shadow_ctrl}, exp_sh);
      end
    end
    if (romsel === 1'b1 || cpu_rw === 1'b0) begin
      checks++;
      if (prev_wr) begin
        errors++;
        $display("FAIL back_to_back_write cyc=%0d got=consecutive want=gap", cyc);
      end
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d addr=%h data=%h", cyc, cpu_addr, cpu_data_o);
      end else begin
        w = wq.pop_front();
        if (cyc != w.cyc || cpu_addr !== w.addr || cpu_data_o !== w.data ||
            cpu_rw !== 1'b0 || romsel !== 1'b1) begin
          errors++;
          $display("FAIL write got cyc=%0d addr=%h data=%h rw=%b romsel=%b want cyc=%0d addr=%h data=%h rw=0 romsel=1",
                   cyc, cpu_addr, cpu_data_o, cpu_rw, romsel, w.cyc, w.addr, w.data);
        end
      end
      prev_wr = 1'b1;
    end else begin
      prev_wr = 1'b0;
    end
    if (done === 1'b1) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d", cyc);
      end else begin
        d = dq.pop_front();
        if (cyc != d.cyc || req_ready !== 1'b0) begin
          errors++;
          $display("FAIL done got cyc=%0d ready=%b want cyc=%0d ready=0", cyc, req_ready, d.cyc);
        end
        exp_sh = d.sh;
        sh_pending = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_accept(output int acc);
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_cpu);
      if (req_ready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=none want=accept");
    end
  endtask

  // Issue one request; push expected writes/done. stall_k<0 means no grant stall.
  task automatic issue(input logic [1:0] sel, input logic [4:0] val, input int stall_k,
                       input int stall_len, input bit hold, input bit abort, output int acc);
    wr_t w;
    dn_t d;
    int  base, slen, nwr;
    req_sel = sel;
    req_val = val;
    req_valid = 1'b1;
    wait_accept(acc);
    if (acc < 0) begin
      req_valid = 1'b0;
      return;
    end
    slen = (stall_k >= 0) ? stall_len : 0;
    base = acc + 1 + P;
    if (P > 0) begin
      w.cyc = acc + 1; w.addr = {sel, ALOW}; w.data = 8'h80;
      wq.push_back(w);
    end
    nwr = abort ? 2 : 5;
    for (int k = 0; k < nwr; k++) begin
      w.cyc  = base + k * (1 + GAP) + ((stall_k >= 0 && k >= stall_k) ? slen : 0);
      w.addr = {sel, ALOW};
      w.data = {7'b0, val[k]};
      wq.push_back(w);
    end
    if (stall_k >= 0) begin
      lo_from = base + stall_k * (1 + GAP);
      lo_to   = lo_from + slen;
    end
    if (!abort) begin
      if (P > 0) m_sh[0] = m_sh[0] | 5'h0C;
      m_sh[sel] = val;
      d.cyc = base + 5 * (1 + GAP) + slen;
      d.sh  = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
      dq.push_back(d);
    end
    @(posedge clk_cpu); #1;
    if (!hold) req_valid = 1'b0;
    if (!hold && !abort)
      while (cyc < d.cyc + 2) begin @(posedge clk_cpu); #1; end
  endtask

  initial begin
    int acc, acc2, w2;
    m_sh[0] = 5'h0C; m_sh[1] = '0; m_sh[2] = '0; m_sh[3] = '0;
    repeat (3) @(posedge clk_cpu);
    #1 rst = 1'b0;
    @(negedge clk_cpu);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_rw",    32'(cpu_rw), 32'd1);
    chk("rst_romsel", 32'(romsel), 32'd0);
    chk("rst_addr",  32'(cpu_addr), 32'd0);
    chk("rst_data",  32'(cpu_data_o), 32'd0);
    chk("rst_sh_ctrl", 32'(shadow_ctrl), 32'h0C);
    chk("rst_sh_chr0", 32'(shadow_chr0), 32'h0);
    chk("rst_sh_chr1", 32'(shadow_chr1), 32'h0);
    chk("rst_sh_prg",  32'(shadow_prg), 32'h0);
    @(posedge clk_cpu); #1;

    // T1 and T2: prg=10110 plain, then with a 3-cycle grant stall at the third write
    issue(2'd3, 5'b10110, -1, 0, 1'b0, 1'b0, acc);
    issue(2'd3, 5'b10110, 2, 3, 1'b0, 1'b0, acc);

    // T3: abort after the second data write of ctrl=1F
    issue(2'd0, 5'h1F, -1, 0, 1'b0, 1'b1, acc);
    w2 = acc + 1 + P + (1 + GAP);
    while (cyc < w2 + 1) begin @(posedge clk_cpu); #1; end
    rst = 1'b1;
    @(posedge clk_cpu); #1;
    rst = 1'b0;
    m_sh[0] = 5'h0C; m_sh[1] = '0; m_sh[2] = '0; m_sh[3] = '0;
    @(negedge clk_cpu);
    chk("abort_rw", 32'(cpu_rw), 32'd1);
    chk("abort_romsel", 32'(romsel), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_sh_ctrl", 32'(shadow_ctrl), 32'h0C);
    chk("abort_queue", 32'(wq.size()), 32'd0);
    @(posedge clk_cpu); #1;

    // Cart programming set
    issue(2'd0, 5'h10, -1, 0, 1'b0, 1'b0, acc);
    issue(2'd1, 5'h02, -1, 0, 1'b0, 1'b0, acc);
    issue(2'd2, 5'h03, -1, 0, 1'b0, 1'b0, acc);
    issue(2'd3, 5'h01, -1, 0, 1'b0, 1'b0, acc);

    // T6: req_valid held high across two requests
    issue(2'd1, 5'h1F, -1, 0, 1'b1, 1'b0, acc);
    issue(2'd2, 5'h0A, -1, 0, 1'b0, 1'b0, acc2);
    chk("b2b_accept_cycle", 32'(acc2), 32'(acc + 1 + P + 5 * (1 + GAP) + 1));

    repeat (4) @(posedge clk_cpu);
    #1;
    chk("end_wq_empty", 32'(wq.size()), 32'd0);
    chk("end_dq_empty", 32'(dq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
